// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory access stage with MAR/MDR, byte-lane steering and misalignment error
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic              req_bw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              rw_q, bw_q, err_q;
    logic [2:0]        cnt;

    logic              accept;
    logic              misaligned;
    logic [DATA_W-1:0] rd_steer;

    assign accept     = req_valid && (state == IDLE);
    assign misaligned = !req_bw && req_addr[0];

    // Byte reads land in the low lane of MDR, zero-extended.
    always_comb begin
        rd_steer = mem_rdata;
        if (bw_q) begin
            if (mar[0]) rd_steer = {{(DATA_W-8){1'b0}}, mem_rdata[15:8]};
            else        rd_steer = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar   <= '0;
            mdr   <= '0;
            rw_q  <= 1'b0;
            bw_q  <= 1'b0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                mar   <= req_addr;
                rw_q  <= req_rw;
                bw_q  <= req_bw;
                err_q <= misaligned;
                // A rejected (misaligned) write must leave MDR untouched.
                if (req_rw && !misaligned) begin
                    if (req_bw) mdr <= {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                    else        mdr <= req_wdata;
                end
            end
            if (state == ACCESS) cnt <= 3'(MEM_LAT);
            if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) mdr <= rd_steer;
            end
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 2'b00;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_en     = 1'b1;
                mem_we     = rw_q;
                mem_be     = bw_q ? (mar[0] ? 2'b10 : 2'b01) : 2'b11;
                next_state = rw_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem_addr  = mar[ADDR_W-1:1];
    assign mem_wdata = bw_q ? {mdr[7:0], mdr[7:0]} : mdr;
    assign resp_data = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit at MEM_LAT 1 (index 0) and 3 (index 1)
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rw, req_bw;
    logic [15:0] req_addr, req_wdata;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        resp_valid [2];
    logic        resp_err [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [15:0] resp_data [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [14:0] mem_addr [2];
    logic [1:0]  mem_be [2];

    int total = 0;
    int bad   = 0;

    int          acc_cnt, en_cyc, rsp_cyc;
    logic        o_we, o_err, o_ready, busy_ok;
    logic [14:0] o_addr;
    logic [1:0]  o_be;
    logic [15:0] o_wdata, o_data;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] mem [256];
        logic [15:0] rd_q = 16'h0;
        int          rd_cnt = 0;

        mem_access_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_rw(req_rw), .req_bw(req_bw), .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid[g]), .resp_data(resp_data[g]), .resp_err(resp_err[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_be(mem_be[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Read data is only valid in the single cycle LAT cycles after ACCESS.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) begin
                if (mem_be[g][0]) mem[mem_addr[g][7:0]][7:0]  <= mem_wdata[g][7:0];
                if (mem_be[g][1]) mem[mem_addr[g][7:0]][15:8] <= mem_wdata[g][15:8];
            end
            if (mem_en[g] && !mem_we[g]) begin
                rd_q   <= mem[mem_addr[g][7:0]];
                rd_cnt <= LAT;
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
            end
        end
        assign mem_rdata[g] = (rd_cnt == 1) ? rd_q : 16'hDEAD;
    end

    task automatic do_req(input int k, input logic rw, input logic bw,
                          input logic [15:0] addr, input logic [15:0] wdata);
        req_rw = rw; req_bw = bw; req_addr = addr; req_wdata = wdata;
        req_valid[k] = 1'b1;
        o_ready = req_ready[k];
        acc_cnt = 0; en_cyc = -1; rsp_cyc = -1; busy_ok = 1'b1;
        o_we = 1'bx; o_addr = 'x; o_be = 'x; o_wdata = 'x; o_err = 1'bx; o_data = 'x;
        for (int c = 1; c <= 12 && rsp_cyc < 0; c++) begin
            @(negedge clk);
            req_valid[k] = 1'b0;
            if (req_ready[k]) busy_ok = 1'b0;
            if (mem_en[k]) begin
                acc_cnt++; en_cyc = c;
                o_we = mem_we[k]; o_addr = mem_addr[k]; o_be = mem_be[k]; o_wdata = mem_wdata[k];
            end
            if (resp_valid[k]) begin
                rsp_cyc = c; o_err = resp_err[k]; o_data = resp_data[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_rw = 1'b0; req_bw = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++; if (req_ready[k] !== 1'b1) begin bad++; $display("FAIL rst_ready[%0d] got=%b want=1", k, req_ready[k]); end
            total++; if ({resp_valid[k], resp_err[k], mem_en[k], mem_we[k], mem_be[k]} !== 6'b0) begin
                bad++; $display("FAIL rst_strobes[%0d] got=%b want=000000", k, {resp_valid[k], resp_err[k], mem_en[k], mem_we[k], mem_be[k]}); end
            total++; if ({resp_data[k], mem_addr[k], mem_wdata[k]} !== 47'h0) begin
                bad++; $display("FAIL rst_data[%0d] got=%h/%h/%h want=0/0/0", k, resp_data[k], mem_addr[k], mem_wdata[k]); end
        end
    endtask

    task automatic test_word_write;
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h1234);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ww_ready got=%b want=1", o_ready); end
        total++; if (en_cyc !== 1 || acc_cnt !== 1) begin bad++; $display("FAIL ww_en got=cyc%0d/n%0d want=cyc1/n1", en_cyc, acc_cnt); end
        total++; if ({o_we, o_addr, o_be} !== {1'b1, 15'h0008, 2'b11}) begin
            bad++; $display("FAIL ww_ctl got=we%b a%h be%b want=we1 a0008 be11", o_we, o_addr, o_be); end
        total++; if (o_wdata !== 16'h1234) begin bad++; $display("FAIL ww_wdata got=%h want=1234", o_wdata); end
        total++; if (rsp_cyc !== 2 || o_err !== 1'b0 || o_data !== 16'h1234) begin
            bad++; $display("FAIL ww_resp got=cyc%0d e%b d%h want=cyc2 e0 d1234", rsp_cyc, o_err, o_data); end
    endtask

    task automatic test_word_read;
        do_req(0, 1'b0, 1'b0, 16'h0010, 16'hFFFF);
        total++; if (en_cyc !== 1 || acc_cnt !== 1 || o_we !== 1'b0) begin
            bad++; $display("FAIL wr_en got=cyc%0d/n%0d we%b want=cyc1/n1 we0", en_cyc, acc_cnt, o_we); end
        total++; if (rsp_cyc !== 3 || o_err !== 1'b0 || o_data !== 16'h1234) begin
            bad++; $display("FAIL wr_resp got=cyc%0d e%b d%h want=cyc3 e0 d1234", rsp_cyc, o_err, o_data); end
        total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL wr_busy_ready got=%b want=1", busy_ok); end
    endtask

    task automatic test_byte_lanes;
        do_req(0, 1'b1, 1'b1, 16'h0011, 16'h77AB);
        total++; if ({o_we, o_be, o_wdata} !== {1'b1, 2'b10, 16'hABAB}) begin
            bad++; $display("FAIL bw_ctl got=we%b be%b d%h want=we1 be10 dABAB", o_we, o_be, o_wdata); end
        total++; if (rsp_cyc !== 2 || o_data !== 16'h00AB) begin
            bad++; $display("FAIL bw_resp got=cyc%0d d%h want=cyc2 d00AB", rsp_cyc, o_data); end
        do_req(0, 1'b0, 1'b1, 16'h0010, 16'h0);
        total++; if (o_be !== 2'b01 || rsp_cyc !== 3 || o_data !== 16'h0034) begin
            bad++; $display("FAIL br_even got=be%b cyc%0d d%h want=be01 cyc3 d0034", o_be, rsp_cyc, o_data); end
        do_req(0, 1'b0, 1'b1, 16'h0011, 16'h0);
        total++; if (o_be !== 2'b10 || rsp_cyc !== 3 || o_data !== 16'h00AB) begin
            bad++; $display("FAIL br_odd got=be%b cyc%0d d%h want=be10 cyc3 d00AB", o_be, rsp_cyc, o_data); end
    endtask

    task automatic test_misaligned;
        do_req(0, 1'b0, 1'b0, 16'h0013, 16'h0);
        total++; if (acc_cnt !== 0) begin bad++; $display("FAIL mis_rd_en got=%0d want=0", acc_cnt); end
        total++; if (rsp_cyc !== 1 || o_err !== 1'b1 || o_data !== 16'h00AB) begin
            bad++; $display("FAIL mis_rd_resp got=cyc%0d e%b d%h want=cyc1 e1 d00AB", rsp_cyc, o_err, o_data); end
        do_req(0, 1'b1, 1'b0, 16'h0015, 16'h5555);
        total++; if (acc_cnt !== 0 || rsp_cyc !== 1 || o_err !== 1'b1 || o_data !== 16'h00AB) begin
            bad++; $display("FAIL mis_wr got=n%0d cyc%0d e%b d%h want=n0 cyc1 e1 d00AB", acc_cnt, rsp_cyc, o_err, o_data); end
    endtask

    task automatic test_wrap;
        do_req(0, 1'b1, 1'b0, 16'hFFFE, 16'h5678);
        do_req(0, 1'b1, 1'b1, 16'hFFFF, 16'h00CD);
        total++; if ({o_addr, o_be, o_wdata} !== {15'h7FFF, 2'b10, 16'hCDCD}) begin
            bad++; $display("FAIL wrap_bw got=a%h be%b d%h want=a7FFF be10 dCDCD", o_addr, o_be, o_wdata); end
        do_req(0, 1'b0, 1'b1, 16'hFFFF, 16'h0);
        total++; if (o_data !== 16'h00CD) begin bad++; $display("FAIL wrap_br got=%h want=00CD", o_data); end
        do_req(0, 1'b0, 1'b0, 16'hFFFE, 16'h0);
        total++; if (o_data !== 16'hCD78) begin bad++; $display("FAIL wrap_wr got=%h want=CD78", o_data); end
    endtask

    task automatic test_reset_abort;
        int pulses = 0;
        req_rw = 1'b0; req_bw = 1'b0; req_addr = 16'h0010; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_data[0] !== 16'h0) begin
            bad++; $display("FAIL abort_state got=r%b v%b d%h want=r1 v0 d0000", req_ready[0], resp_valid[0], resp_data[0]); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid[0]) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_resp got=%0d want=0", pulses); end
        do_req(0, 1'b0, 1'b0, 16'h0010, 16'h0);
        total++; if (rsp_cyc !== 3 || o_data !== 16'hAB34) begin
            bad++; $display("FAIL abort_fresh got=cyc%0d d%h want=cyc3 dAB34", rsp_cyc, o_data); end
    endtask

    task automatic test_reset_with_req;
        req_rw = 1'b1; req_bw = 1'b0; req_addr = 16'h0010; req_wdata = 16'hBEEF;
        rst = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid[0] = 1'b0;
        total++; if (req_ready[0] !== 1'b1 || mem_en[0] !== 1'b0) begin
            bad++; $display("FAIL rstreq_idle got=r%b en%b want=r1 en0", req_ready[0], mem_en[0]); end
        @(negedge clk);
        total++; if (mem_en[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            bad++; $display("FAIL rstreq_noaccept got=en%b v%b r%b want=en0 v0 r1", mem_en[0], resp_valid[0], req_ready[0]); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int r1 = -1, r2 = -1;
        logic [15:0] d1 = 'x, d2 = 'x;
        logic rdy5 = 1'bx, rdy6 = 1'bx;
        do_req(1, 1'b1, 1'b0, 16'h0020, 16'h1111);
        do_req(1, 1'b1, 1'b0, 16'h0022, 16'h2222);
        req_rw = 1'b0; req_bw = 1'b0; req_addr = 16'h0020; req_valid[1] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                pulses++;
                if (r1 < 0) begin r1 = c; d1 = resp_data[1]; end
                else begin r2 = c; d2 = resp_data[1]; end
            end
            if (c == 5) rdy5 = req_ready[1];
            if (c == 6) rdy6 = req_ready[1];
            if (c == 1) req_addr = 16'h0022;
            if (c == 7) req_valid[1] = 1'b0;
        end
        total++; if (r1 !== 5 || d1 !== 16'h1111) begin bad++; $display("FAIL b2b_first got=cyc%0d d%h want=cyc5 d1111", r1, d1); end
        total++; if (rdy5 !== 1'b0 || rdy6 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=c5:%b c6:%b want=c5:0 c6:1", rdy5, rdy6); end
        total++; if (r2 !== 11 || d2 !== 16'h2222) begin bad++; $display("FAIL b2b_second got=cyc%0d d%h want=cyc11 d2222", r2, d2); end
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_lanes();
        test_misaligned();
        test_wrap();
        test_reset_abort();
        test_reset_with_req();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage between the control unit and the byte-addressed, word-wide data/instruction memory. The control unit issues one request at a time through a ready/valid handshake. The block holds the request in its MAR/MDR registers and runs one memory cycle with byte-lane steering. It returns read data (the MDR value) to the bus and instruction register, and reports an error for a misaligned word access.

## Interface
Parameters:
- `ADDR_W`, default 16: byte address width.
- `DATA_W`, default 16: word width. Fixed at 16; byte lanes are `[7:0]` (even address) and `[15:8]` (odd address), little-endian.
- `MEM_LAT`, default 1: memory read latency in cycles. Legal range 1..4.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; equals 1 exactly when state is IDLE.
- `req_rw` in 1: 0 = read, 1 = write.
- `req_bw` in 1: 0 = word, 1 = byte.
- `req_addr` in 16: byte address.
- `req_wdata` in 16: write data; byte writes use bits `[7:0]`.
- `resp_valid` out 1: one-cycle pulse; the request is complete.
- `resp_data` out 16: MDR contents; holds its value between responses.
- `resp_err` out 1: qualified by `resp_valid`; 1 = misaligned word access.
- `mem_en` out 1: memory cycle strobe.
- `mem_we` out 1: write enable; qualified by `mem_en`.
- `mem_addr` out 15: word address, equal to MAR[15:1].
- `mem_be` out 2: byte enables; bit 0 selects `[7:0]`, bit 1 selects `[15:8]`.
- `mem_wdata` out 16: write data to memory.
- `mem_rdata` in 16: read data from memory.

## Operation
- **Accept.** A request is accepted when `req_valid && req_ready && !rst` on a rising edge. On acceptance the block latches:
  - MAR ← `req_addr`; rw and bw flags.
  - Write: MDR ← `req_wdata`, or `{8'h00, req_wdata[7:0]}` for a byte write.
- **States:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - Word request with `req_addr[0] = 1` → RESP with the error flag set. No memory cycle occurs.
  - Any other request → ACCESS.
- **ACCESS** (exactly one cycle):
  - `mem_en = 1`, `mem_we = rw`, `mem_addr = MAR[15:1]`.
  - `mem_be`: word → `2'b11`; byte → `2'b01` if MAR[0] = 0, `2'b10` if MAR[0] = 1.
  - `mem_wdata`: word → MDR; byte → `{MDR[7:0], MDR[7:0]}` (lane replicated).
  - Next state: write → RESP; read → WAIT.
- **WAIT:**
  - Lasts exactly `MEM_LAT` cycles, counted by an internal down-counter.
  - On the final WAIT edge, `mem_rdata` is captured into MDR:
    - word → `mem_rdata`;
    - byte at even address → `{8'h00, mem_rdata[7:0]}`;
    - byte at odd address → `{8'h00, mem_rdata[15:8]}`.
  - Then → RESP.
- **RESP** (one cycle):
  - `resp_valid = 1`; `resp_err` = error flag; `resp_data` = MDR.
  - `req_ready = 0`. Next state is IDLE.
- **MDR on error:** unchanged by an error response. `resp_data` keeps its previous value.
- **Outputs outside their states:** `mem_en`, `mem_we`, `mem_be`, `resp_valid` and `resp_err` are 0 outside ACCESS/RESP. `mem_addr` and `mem_wdata` are don't-care when `mem_en = 0`, but must be driven from MAR/MDR.
- **Busy requests:** requests presented while not in IDLE are not accepted. The requester must hold them; they have no effect.

## Timing
- Cycle 0 is the cycle in which the request is accepted.
- **Read:** ACCESS in cycle 1; WAIT in cycles 2..1+`MEM_LAT`; RESP in cycle 2+`MEM_LAT`.
- **Write:** ACCESS in cycle 1; RESP in cycle 2.
- **Misaligned word access:** RESP in cycle 1.
- **Back-to-back:** the next request can be accepted in the cycle after RESP, since IDLE has `req_ready = 1`. Sustained reads therefore take 3+`MEM_LAT` cycles each.
- **Memory contract:** `mem_rdata` is valid `MEM_LAT` cycles after the ACCESS cycle and is sampled only on the final WAIT edge.
- **Reset values:** state = IDLE, MAR = 0, MDR = 0, counter = 0. Outputs are then:
  - `req_ready = 1`;
  - `resp_valid = 0`, `resp_err = 0`, `resp_data = 0`;
  - `mem_en = 0`, `mem_we = 0`, `mem_be = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Reset mid-operation:** `rst` asserted in any state aborts the access. The next cycle is IDLE, and no `resp_valid` is produced for the aborted request.
  - `rst` during ACCESS of a write: the write strobe completes in that cycle and is not retracted.
- **Simultaneous reset and request:** `rst` and `req_valid` in the same cycle → reset wins and the request is not accepted.
- **Address wrap:** MAR = 0xFFFF → `mem_addr = 0x7FFF`, upper lane. There is no wrap logic; the address is used as-is.

## Test plan
- Reset, then word write 0x1234 @ 0x0010 → cycle 1: `mem_en = 1`, `mem_we = 1`, `mem_addr = 0x0008`, `mem_be = 11`, `mem_wdata = 0x1234`. Cycle 2: `resp_valid = 1`, `resp_err = 0`, `resp_data = 0x1234`.
- `MEM_LAT = 1`, word read @ 0x0010 with memory returning 0x1234 → `mem_en` only in cycle 1, `mem_we = 0`. Cycle 3: `resp_valid = 1`, `resp_data = 0x1234`. `req_ready = 0` in cycles 1–3.
- Byte write 0x00AB @ 0x0011 → `mem_be = 10`, `mem_wdata = 0xABAB`. Then, with the memory word at 0x0008 equal to 0xAB34:
  - byte read @ 0x0011 → `resp_data = 0x00AB`;
  - byte read @ 0x0010 → `resp_data = 0x0034`.
- With prior `resp_data = 0x00AB`, word read @ 0x0013 → no `mem_en`. Cycle 1: `resp_valid = 1`, `resp_err = 1`, `resp_data = 0x00AB`.
- `MEM_LAT = 3`, `req_valid` held high with two reads → first response in cycle 5. Second request accepted in cycle 6, response in cycle 11. Exactly two `resp_valid` pulses.
- `rst` asserted in the first WAIT cycle of a read → next cycle: IDLE, `req_ready = 1`, `resp_data = 0`. No `resp_valid` for the aborted read; a fresh request is accepted normally.
